// File: rtl/spi_master_shifter_if.sv
// Controller-side bus of the SPI master shifter: write strobe with data/address,
// enable, received word and status pulses.
interface spi_master_shifter_if #(
  parameter int data    = 8,
  parameter int address = 3
);
  logic               spe;
  logic               m_wr_stb;
  logic [address-1:0] m_addr;
  logic [data-1:0]    m_wdata;
  logic [data-1:0]    m_rdata;
  logic               SPTEF;
  logic               TXC;
  logic               WCOL;

  modport master (
    output spe, m_wr_stb, m_addr, m_wdata,
    input  m_rdata, SPTEF, TXC, WCOL
  );

  modport slave (
    input  spe, m_wr_stb, m_addr, m_wdata,
    output m_rdata, SPTEF, TXC, WCOL
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shifter with one-entry transmit buffer and one-hot slave selects.
// Define SPI_LSBFE_EN to shift LSB first (default build is MSB first).
module spi_master_shifter #(
  parameter int data    = 8,
  parameter int address = 3,
  parameter int DIV     = 4
) (
  input  logic                   CLK,
  input  logic                   PRESET,
  spi_master_shifter_if.slave    bus,
  input  logic                   MISO,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic [2**address-1:0]  SS_n
);
  localparam int NSS = 2**address;
  localparam int HPW = $clog2(2*data);
  localparam logic [HPW-1:0] HP_LAST      = HPW'(2*data-1);
  localparam logic [HPW-1:0] HP_LAST_FALL = HPW'(2*data-2);
  localparam logic [7:0]     DIV_LAST     = 8'(DIV-1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t             state_q;
  logic [7:0]         cnt_q;
  logic [HPW-1:0]     hp_q;
  logic [data-1:0]    tx_q, rx_q, rdata_q, buf_data_q;
  logic [address-1:0] buf_addr_q;
  logic               sptef_q, txc_q, wcol_q, sclk_q, mosi_q;
  logic [NSS-1:0]     ss_n_q;
  logic               abort, start, accept, collide;

`ifdef SPI_LSBFE_EN
  function automatic logic first_bit(input logic [data-1:0] w);
    return w[0];
  endfunction
  function automatic logic [data-1:0] tx_shift(input logic [data-1:0] w);
    return {1'b0, w[data-1:1]};
  endfunction
  function automatic logic [data-1:0] rx_shift(input logic [data-1:0] w, input logic b);
    return {b, w[data-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [data-1:0] w);
    return w[data-1];
  endfunction
  function automatic logic [data-1:0] tx_shift(input logic [data-1:0] w);
    return {w[data-2:0], 1'b0};
  endfunction
  function automatic logic [data-1:0] rx_shift(input logic [data-1:0] w, input logic b);
    return {w[data-2:0], b};
  endfunction
`endif

  // A load frees the buffer in the same cycle, so a write arriving then is taken.
  assign abort   = (state_q != IDLE) && !bus.spe;
  assign start   = (state_q == IDLE || state_q == DONE) && !sptef_q && bus.spe;
  assign accept  = bus.m_wr_stb && bus.spe && (sptef_q || start);
  assign collide = bus.m_wr_stb && bus.spe && !sptef_q && !start;

  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hp_q       <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      buf_data_q <= '0;
      buf_addr_q <= '0;
      sptef_q    <= 1'b1;
      txc_q      <= 1'b0;
      wcol_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      txc_q  <= 1'b0;
      wcol_q <= collide;

      if (abort) begin
        sptef_q <= 1'b1;
      end else if (accept) begin
        sptef_q    <= 1'b0;
        buf_data_q <= bus.m_wdata;
        buf_addr_q <= bus.m_addr;
      end else if (start) begin
        sptef_q <= 1'b1;
      end

      if (abort) begin
        state_q <= IDLE;
        ss_n_q  <= '1;
        sclk_q  <= 1'b0;
        mosi_q  <= 1'b0;
        cnt_q   <= '0;
        hp_q    <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              state_q <= LEAD;
              tx_q    <= buf_data_q;
              mosi_q  <= first_bit(buf_data_q);
              ss_n_q  <= ~(NSS'(1) << buf_addr_q);
              cnt_q   <= '0;
              hp_q    <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
          LEAD: begin
            if (cnt_q == DIV_LAST) begin
              state_q <= SHIFT;
              cnt_q   <= '0;
              hp_q    <= '0;
              sclk_q  <= 1'b1;
              rx_q    <= rx_shift(rx_q, MISO);
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          SHIFT: begin
            // Half-periods alternate high/low; the final low half flows into TRAIL.
            if (cnt_q == DIV_LAST) begin
              cnt_q <= '0;
              if (hp_q == HP_LAST) begin
                state_q <= TRAIL;
              end else begin
                hp_q   <= hp_q + 1'b1;
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                  if (hp_q != HP_LAST_FALL) begin
                    tx_q   <= tx_shift(tx_q);
                    mosi_q <= first_bit(tx_shift(tx_q));
                  end
                end else begin
                  rx_q <= rx_shift(rx_q, MISO);
                end
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          TRAIL: begin
            if (cnt_q == DIV_LAST) begin
              state_q <= DONE;
              cnt_q   <= '0;
              rdata_q <= rx_q;
              txc_q   <= 1'b1;
              ss_n_q  <= '1;
              mosi_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.m_rdata = rdata_q;
  assign bus.SPTEF   = sptef_q;
  assign bus.TXC     = txc_q;
  assign bus.WCOL    = wcol_q;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign SS_n        = ss_n_q;
endmodule
